// File: rtl/expr_eval.sv
// Evaluates single-digit '+'/'*' expressions from an ASCII stream, '*' binding tighter than '+'.
// Each '=' produces a one-cycle done pulse together with the registered result and error flag.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {S_IDLE, S_NUM, S_OP, S_ERR} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sum, term, sum_nx, term_nx, result_nx;
  logic             pend_mul, pend_nx, done_nx, error_nx;
  logic             is_digit, is_plus, is_mul, is_eq;
  logic [WIDTH-1:0] digit;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_plus  = (in == 8'h2B);
  assign is_mul   = (in == 8'h2A);
  assign is_eq    = (in == 8'h3D);
  assign digit    = WIDTH'(in[3:0]);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nx;
  end

  // '=' always returns to idle; otherwise the grammar is digit (op digit)*
  always_comb begin
    state_nx = state;
    if (in_valid) begin
      if (is_eq) begin
        state_nx = S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_OP: state_nx = is_digit ? S_NUM : S_ERR;
          S_NUM:        state_nx = (is_plus || is_mul) ? S_OP : S_ERR;
          default:      state_nx = S_ERR;
        endcase
      end
    end
  end

  always_comb begin
    sum_nx    = sum;
    term_nx   = term;
    pend_nx   = pend_mul;
    result_nx = result;
    error_nx  = error;
    done_nx   = 1'b0;
    if (in_valid) begin
      if (is_eq) begin
        sum_nx   = '0;
        term_nx  = '0;
        pend_nx  = 1'b0;
        done_nx  = 1'b1;
        if (state == S_NUM) begin
          result_nx = sum + term;
          error_nx  = 1'b0;
        end else begin
          result_nx = '0;
          error_nx  = 1'b1;
        end
      end else if ((state == S_IDLE || state == S_OP) && is_digit) begin
        term_nx = pend_mul ? term * digit : digit;
      end else if (state == S_NUM && is_plus) begin
        sum_nx  = sum + term;
        pend_nx = 1'b0;
      end else if (state == S_NUM && is_mul) begin
        pend_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sum      <= '0;
      term     <= '0;
      pend_mul <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      sum      <= sum_nx;
      term     <= term_nx;
      pend_mul <= pend_nx;
      result   <= result_nx;
      done     <= done_nx;
      error    <= error_nx;
    end
  end

endmodule

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream companion to the character-stream expression recogniser; consumes the same ASCII byte stream, one character per valid cycle.
- Evaluates single-digit expressions using '+' and '*', with '*' binding tighter than '+'. The character '=' terminates an expression.
- Emits the registered result plus a one-cycle done pulse and an error flag, for the display/checker stage.

Parameters:
- WIDTH, 16, bit width of the accumulators and of result; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-low. clr=0 immediately forces the reset state.
- in_valid  input  1  in holds a character this cycle; when 0 the block holds all state.
- in  input  8  ASCII character: '0'..'9' (8'h30..8'h39), '+' (8'h2B), '*' (8'h2A), '=' (8'h3D); any other value is illegal.
- result  output  WIDTH  value of the last terminated expression.
- done  output  1  one-cycle pulse when result/error update.
- error  output  1  last terminated expression was malformed; valid while done=1 and held afterwards.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=S_IDLE, sum=0, term=0, pend_mul=0.
  - result=0, done=0, error=0.
- Internal registers:
  - sum: running total of completed product terms.
  - term: current product term.
  - pend_mul: previous operator was '*'.
- States: S_IDLE (expect first digit), S_NUM (digit just taken; expect operator or '='), S_OP (operator just taken; expect digit), S_ERR (malformed; discard until '=').
- Updates happen only on cycles with in_valid=1. done is 0 on every cycle not listed below.
- S_IDLE / S_OP on digit d:
  - term <= pend_mul ? term*d : d (truncated to WIDTH).
  - Go to S_NUM.
- S_NUM on '+': sum <= sum+term, pend_mul <= 0, go to S_OP.
- S_NUM on '*': pend_mul <= 1, go to S_OP.
- S_NUM on '=':
  - Next cycle result=sum+term (mod 2^WIDTH), error=0, done=1.
  - Clear sum, term and pend_mul; go to S_IDLE.
- '=' in S_IDLE, S_OP or S_ERR:
  - Next cycle result=0, error=1, done=1.
  - Clear sum, term and pend_mul; go to S_IDLE.
- Any other character in S_IDLE/S_NUM/S_OP (operator where a digit is expected, a digit where an operator is expected, or an illegal code): go to S_ERR, no output change.
- S_ERR on anything except '=': stay in S_ERR.
- Latency: '=' accepted at edge N gives done=1 with the new result/error during the cycle after edge N, for exactly one cycle.
- result and error hold their values until the next done.
- Back-to-back expressions: the first digit may arrive on the cycle right after '='. No dead cycle.
- in_valid=0 gaps may occur anywhere, including between '=' and the next character, with no effect on the outcome.
- Overflow wraps silently; no error is raised.
- Reset mid-expression discards partial state. The first expression after reset is evaluated from scratch.

Test Plan:
- "1+2+3=" with in_valid=1 each cycle -> one cycle after '=': done=1, result=6, error=0; done=0 on the next cycle.
- "2+3*4=", then immediately "2*3*4+1=" -> results 14 and then 25, two distinct done pulses, no dead cycle needed between expressions.
- "1++2=" then "5=" -> first done: error=1, result=0. Second done: error=0, result=5. "=" alone -> error=1.
- "1+2" then clr=0 for 3 ns between edges (asynchronous: outputs zero immediately), then "3=" -> result=3, error=0.
- "7", in_valid=0 for 3 cycles, "+8=" -> result=15. A character presented while in_valid=0 (e.g. 'x') has no effect.
- WIDTH=4: "9*9=" -> result=4'h1 (81 mod 16), error=0. Illegal char "3a=" -> error=1.
